// File: rtl/mul_div_sequencer.sv
// mul_div_sequencer: iterative RV32M multiply/divide unit for the Execute stage.
// Runs one shift-add (multiply) or restoring shift-subtract (divide) step per cycle
// on operand magnitudes, then fixes the sign when the result is written.
// Divide-by-zero and signed-overflow divides skip the iteration entirely.
// Ports:
//   clk, rstN         clock (rising edge) and asynchronous active-low reset
//   start             EX stage holds a valid M op (level)
//   func3             RV32M op select (MUL..REMU)
//   operandA/B        rs1 / rs2 values
//   flush             abort any op in flight
//   stallReq          freeze IF/ID/EX this cycle (combinational)
//   busy              FSM not idle
//   resultValid       result valid this cycle (one pulse)
//   result            registered result, updated on entry to DONE
module mul_div_sequencer #(
   parameter int unsigned XLEN = 32
) (
   input  logic            clk,
   input  logic            rstN,
   input  logic            start,
   input  logic [2:0]      func3,
   input  logic [XLEN-1:0] operandA,
   input  logic [XLEN-1:0] operandB,
   input  logic            flush,
   output logic            stallReq,
   output logic            busy,
   output logic            resultValid,
   output logic [XLEN-1:0] result
);

   localparam int unsigned CNT_W = $clog2(XLEN);
   localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [CNT_W-1:0]    r_cnt;
   logic [2:0]          r_func3;
   logic [XLEN-1:0]     r_mag_a;
   logic [XLEN-1:0]     r_mag_b;
   logic                r_neg_res;
   logic                r_neg_rem;
   logic [2*XLEN-1:0]   r_acc;
   logic [XLEN-1:0]     r_result;

   logic                w_accept;
   logic                w_calc_step;
   logic                w_signed_a;
   logic                w_signed_b;
   logic                w_neg_a;
   logic                w_neg_b;
   logic [XLEN-1:0]     w_mag_a_in;
   logic [XLEN-1:0]     w_mag_b_in;
   logic                w_div_zero;
   logic                w_div_ovf;
   logic                w_special;
   logic [XLEN-1:0]     w_special_val;
   logic [XLEN-1:0]     w_addend;
   logic [XLEN:0]       w_mul_sum;
   logic [2*XLEN-1:0]   w_mul_acc;
   logic [XLEN:0]       w_rem_sh;
   logic [XLEN:0]       w_rem_diff;
   logic [2*XLEN-1:0]   w_div_acc;
   logic [2*XLEN-1:0]   w_acc_step;
   logic [2*XLEN-1:0]   w_prod;
   logic [XLEN-1:0]     w_quot;
   logic [XLEN-1:0]     w_rem;
   logic [XLEN-1:0]     w_final;

   // Operand decode at accept: signedness, magnitudes, fast-path detection
   assign w_signed_a    = func3[2] ? ~func3[0] : (func3[1:0] != 2'b11);
   assign w_signed_b    = func3[2] ? ~func3[0] : ~func3[1];
   assign w_neg_a       = w_signed_a & operandA[XLEN-1];
   assign w_neg_b       = w_signed_b & operandB[XLEN-1];
   assign w_mag_a_in    = w_neg_a ? -operandA : operandA;
   assign w_mag_b_in    = w_neg_b ? -operandB : operandB;
   assign w_div_zero    = (operandB == '0);
   assign w_div_ovf     = ~func3[0] & (operandA == MIN_NEG) & (operandB == '1);
   assign w_special     = func3[2] & (w_div_zero | w_div_ovf);
   assign w_special_val = w_div_zero ? (func3[1] ? operandA : '1)
                                     : (func3[1] ? '0 : MIN_NEG);

   // Multiply step: acc = {partial product high, remaining multiplier bits}
   assign w_addend  = r_acc[0] ? r_mag_a : '0;
   assign w_mul_sum = {1'b0, r_acc[2*XLEN-1:XLEN]} + {1'b0, w_addend};
   assign w_mul_acc = {w_mul_sum, r_acc[XLEN-1:1]};

   // Divide step: acc = {partial remainder, dividend bits shifting into quotient};
   // the borrow bit of the trial subtract decides restore vs. keep
   assign w_rem_sh   = {r_acc[2*XLEN-1:XLEN], r_acc[XLEN-1]};
   assign w_rem_diff = w_rem_sh - {1'b0, r_mag_b};
   assign w_div_acc  = w_rem_diff[XLEN] ? {w_rem_sh[XLEN-1:0], r_acc[XLEN-2:0], 1'b0}
                                        : {w_rem_diff[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};

   assign w_acc_step = r_func3[2] ? w_div_acc : w_mul_acc;

   // Sign fix-up applied to the final step's value as it is written to result
   assign w_prod = r_neg_res ? -w_acc_step : w_acc_step;
   assign w_quot = r_neg_res ? -w_acc_step[XLEN-1:0] : w_acc_step[XLEN-1:0];
   assign w_rem  = r_neg_rem ? -w_acc_step[2*XLEN-1:XLEN] : w_acc_step[2*XLEN-1:XLEN];

   always_comb begin
      w_final = w_prod[2*XLEN-1:XLEN];
      case (r_func3)
         3'b000:         w_final = w_prod[XLEN-1:0];
         3'b100, 3'b101: w_final = w_quot;
         3'b110, 3'b111: w_final = w_rem;
         default:        w_final = w_prod[2*XLEN-1:XLEN];
      endcase
   end

   // State register
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   // Next-state logic; flush overrides everything
   always_comb begin
      w_state_nxt = r_state;
      if (flush) begin
         w_state_nxt = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE:  if (start) w_state_nxt = w_special ? S_DONE : S_CALC;
            S_CALC:  if (r_cnt == '0) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
         endcase
      end
   end

   // Output and datapath-control decode
   always_comb begin
      w_accept    = 1'b0;
      w_calc_step = 1'b0;
      stallReq    = 1'b0;
      busy        = (r_state != S_IDLE);
      resultValid = (r_state == S_DONE);
      case (r_state)
         S_IDLE: begin
            w_accept = start & ~flush;
            stallReq = start & ~flush;
         end
         S_CALC: begin
            w_calc_step = ~flush;
            stallReq    = 1'b1;
         end
         default: ;
      endcase
   end

   // Datapath: operand latch at accept, one iteration per CALC cycle
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         r_cnt     <= '0;
         r_func3   <= '0;
         r_mag_a   <= '0;
         r_mag_b   <= '0;
         r_neg_res <= 1'b0;
         r_neg_rem <= 1'b0;
         r_acc     <= '0;
         r_result  <= '0;
      end else if (w_accept) begin
         r_func3   <= func3;
         r_mag_a   <= w_mag_a_in;
         r_mag_b   <= w_mag_b_in;
         r_neg_res <= w_neg_a ^ w_neg_b;
         r_neg_rem <= w_neg_a;
         r_cnt     <= CNT_W'(XLEN-1);
         r_acc     <= func3[2] ? {{XLEN{1'b0}}, w_mag_a_in} : {{XLEN{1'b0}}, w_mag_b_in};
         if (w_special) r_result <= w_special_val;
      end else if (w_calc_step) begin
         r_acc <= w_acc_step;
         r_cnt <= r_cnt - CNT_W'(1);
         if (r_cnt == '0) r_result <= w_final;
      end
   end

   assign result = r_result;

endmodule

// File: tb/tb_mul_div_sequencer.sv
// Directed bench for mul_div_sequencer: expected results are queued when an op
// is driven and popped when resultValid is observed.
module tb_mul_div_sequencer;

   logic        clk;
   logic        rstN;
   logic        start;
   logic [2:0]  func3;
   logic [31:0] operandA;
   logic [31:0] operandB;
   logic        flush;
   logic        stallReq;
   logic        busy;
   logic        resultValid;
   logic [31:0] result;

   int checks = 0;
   int errors = 0;
   logic [31:0] sb[$];

   mul_div_sequencer #(.XLEN(32)) dut (
      .clk         (clk),
      .rstN        (rstN),
      .start       (start),
      .func3       (func3),
      .operandA    (operandA),
      .operandB    (operandB),
      .flush       (flush),
      .stallReq    (stallReq),
      .busy        (busy),
      .resultValid (resultValid),
      .result      (result)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Called just after a negedge: drive one op, measure latency and stall cycles,
   // compare the result against the scoreboard, then confirm return to IDLE.
   task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
      int lat;
      int stalls;
      logic [31:0] exp_q;
      lat    = 0;
      stalls = 0;
      func3    = f3;
      operandA = a;
      operandB = b;
      start    = 1'b1;
      sb.push_back(exp_res);
      #1;
      if (stallReq) stalls++;
      @(posedge clk);
      #1;
      start = 1'b0;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (stallReq) stalls++;
         if (resultValid) begin
            lat = k;
            break;
         end
      end
      chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
      chk({tag, "_stalls"}, 32'(stalls), 32'(exp_lat));
      exp_q = (sb.size() != 0) ? sb.pop_front() : 32'hDEAD_BEEF;
      chk({tag, "_result"}, result, exp_q);
      @(negedge clk);
      chk({tag, "_valid_drop"}, 32'(resultValid), 32'd0);
      chk({tag, "_idle"}, 32'(busy), 32'd0);
   endtask

   initial begin
      int nvalid;
      int nbusy;
      rstN     = 1'b0;
      start    = 1'b0;
      flush    = 1'b0;
      func3    = 3'b000;
      operandA = '0;
      operandB = '0;
      #1;
      chk("rst_stall", 32'(stallReq), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_valid", 32'(resultValid), 32'd0);
      chk("rst_result", result, 32'd0);
      @(negedge clk);
      rstN = 1'b1;
      @(negedge clk);

      // Multiply family
      run_op("mul_neg",  3'b000, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
      run_op("mulh",     3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33);
      run_op("mulhu",    3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
      run_op("mulhsu",   3'b010, 32'hFFFF_FFFF, 32'd2,        32'hFFFF_FFFF, 33);
      run_op("mul_b0",   3'b000, 32'd1234,     32'd0,        32'd0,        33);

      // Divide family
      run_op("div_neg",  3'b100, 32'hFFFF_FFF9, 32'd2,  32'hFFFF_FFFD, 33);
      run_op("rem_neg",  3'b110, 32'hFFFF_FFF9, 32'd2,  32'hFFFF_FFFF, 33);
      run_op("divu",     3'b101, 32'd100,      32'd7,  32'd14,       33);
      run_op("remu",     3'b111, 32'd100,      32'd7,  32'd2,        33);

      // Fast-path cases
      run_op("divu_z",   3'b101, 32'd5,        32'd0,        32'hFFFF_FFFF, 1);
      run_op("rem_z",    3'b110, 32'd5,        32'd0,        32'd5,        1);
      run_op("rem_ovf",  3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,        1);
      run_op("div_ovf",  3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);

      // Flush ten cycles into CALC: no result, old result retained
      func3    = 3'b100;
      operandA = 32'd1000;
      operandB = 32'd3;
      start    = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (10) @(negedge clk);
      chk("flush_pre_busy", 32'(busy), 32'd1);
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      chk("flush_busy", 32'(busy), 32'd0);
      chk("flush_stall", 32'(stallReq), 32'd0);
      chk("flush_valid", 32'(resultValid), 32'd0);
      chk("flush_result", result, 32'h8000_0000);
      nvalid = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (resultValid) nvalid++;
      end
      chk("flush_no_valid", 32'(nvalid), 32'd0);
      run_op("mul_after_flush", 3'b000, 32'd3, 32'd4, 32'd12, 33);

      // Async reset mid-CALC
      func3    = 3'b000;
      operandA = 32'd5;
      operandB = 32'd6;
      start    = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (5) @(negedge clk);
      rstN = 1'b0;
      #1;
      chk("arst_stall", 32'(stallReq), 32'd0);
      chk("arst_busy", 32'(busy), 32'd0);
      chk("arst_valid", 32'(resultValid), 32'd0);
      chk("arst_result", result, 32'd0);
      repeat (2) @(negedge clk);
      rstN   = 1'b1;
      nvalid = 0;
      nbusy  = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (resultValid) nvalid++;
         if (busy) nbusy++;
      end
      chk("arst_no_valid", 32'(nvalid), 32'd0);
      chk("arst_no_busy", 32'(nbusy), 32'd0);

      // Back-to-back: second op driven in the IDLE cycle right after DONE
      run_op("b2b_divu", 3'b101, 32'd100, 32'd7, 32'd14, 33);
      run_op("b2b_mul",  3'b000, 32'd3,   32'd4, 32'd12, 33);
      run_op("b2b_div_z", 3'b100, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF, 1);

      chk("sb_empty", 32'(sb.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mul_div_sequencer.md
Name: mul_div_sequencer

Overview:
- Iterative RV32M multiply/divide unit with its sequencing FSM, sitting in the Execute stage beside the single-cycle ALU.
- Accepts an M-extension op from the EX stage and holds the pipeline stalled while it iterates one bit per cycle.
- Returns a one-cycle-valid result that the EX/MEM register captures in place of the ALU result.
- Div-by-zero and signed-overflow cases take a fast path with no iteration.

Parameters:
- XLEN, 32, operand/result width.
- CNT_W, $clog2(XLEN), width of the iteration counter.

Ports:
- clk  input  1  system clock, rising edge.
- rstN  input  1  asynchronous active-low reset.
- start  input  1  EX stage holds a valid M-extension op; level, held while stallReq=1.
- func3  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- operandA  input  XLEN  rs1 value (multiplicand/dividend).
- operandB  input  XLEN  rs2 value (multiplier/divisor).
- flush  input  1  branch/jump flush; aborts any op.
- stallReq  output  1  freeze IF/ID/EX this cycle.
- busy  output  1  FSM not IDLE.
- resultValid  output  1  result valid this cycle.
- result  output  XLEN  computed value.

Behaviour:
- Reset (rstN=0, asynchronous): state=IDLE, counter=0, all internal registers=0, stallReq=0, busy=0, resultValid=0, result=0.
- States: IDLE, CALC, DONE.
- IDLE:
  - start=1 & flush=0 latches func3, operand magnitudes, sign flags and special-case flags.
  - Normal op goes to CALC with counter=XLEN-1.
  - Special case goes directly to DONE.
- CALC:
  - One shift-add (multiply) or restoring shift-subtract (divide) step per cycle on magnitudes.
  - Counter decrements each cycle; counter==0 goes to DONE.
  - Exactly XLEN cycles are spent in CALC.
- DONE:
  - resultValid=1 for exactly one cycle, then return to IDLE.
  - start is not sampled in DONE. The pipeline advances in this cycle, so start seen in the following IDLE belongs to the next instruction.
- Latency: accept edge T, CALC on cycles T+1..T+XLEN, resultValid on cycle T+XLEN+1 (33 cycles after accept for XLEN=32). Fast path: resultValid on cycle T+1.
- stallReq is combinational: (state==IDLE & start & ~flush) | state==CALC. It is 0 in DONE.
- busy = (state != IDLE).
- result is registered and updated only on entry to DONE. It holds its value in IDLE until the next DONE.
- Sign handling:
  - MUL, MULH, DIV and REM treat both operands as signed.
  - MULHSU treats A as signed and B as unsigned.
  - MULHU, DIVU and REMU treat both as unsigned.
  - The product is negated when the operand signs differ.
  - The quotient is negated when the signs differ; the remainder takes the sign of the dividend.
- Result selection: MUL returns product[XLEN-1:0]; MULH, MULHSU and MULHU return product[2*XLEN-1:XLEN]; DIV/DIVU return the quotient; REM/REMU return the remainder.
- Special cases (fast path):
  - operandB==0: DIV/DIVU return all ones; REM/REMU return operandA.
  - DIV with A=0x80000000, B=0xFFFFFFFF returns 0x80000000; REM with the same operands returns 0.
  - A multiply with B==0 is not a special case; it iterates normally.
- flush=1 in any state forces IDLE next cycle, with no resultValid and result unchanged. flush has priority over start and over the counter==0 transition.
- An async reset mid-CALC returns everything to reset values immediately. No stale resultValid appears after rstN deasserts.
- An unknown func3 cannot occur, since the decoder gates start. func3 is latched at accept, so changes during CALC are ignored.

Test Plan:
- MUL A=7, B=0xFFFFFFFD -> stallReq high 33 cycles; resultValid one cycle, 33 cycles after accept; result=0xFFFFFFEB; then IDLE.
- MULH A=B=0x80000000 -> 0x40000000. MULHU A=B=0xFFFFFFFF -> 0xFFFFFFFE. MULHSU A=0xFFFFFFFF, B=2 -> 0xFFFFFFFF.
- DIV A=0xFFFFFFF9 (-7), B=2 -> 0xFFFFFFFD. REM with the same operands -> 0xFFFFFFFF. DIVU A=100, B=7 -> 14. REMU with the same operands -> 2.
- DIVU A=5, B=0 -> 0xFFFFFFFF, with resultValid the cycle after accept. REM A=5, B=0 -> 5. DIV A=0x80000000, B=0xFFFFFFFF -> 0x80000000, also on the fast path.
- Start a DIV, assert flush 10 cycles into CALC -> IDLE next cycle, no resultValid, result keeps its previous value. A new MUL 3*4 then -> 12.
- Drop rstN low mid-CALC -> all outputs 0 immediately. Release with start=0 -> stays IDLE with resultValid=0. Back-to-back ops (start re-asserted the cycle after DONE) are both accepted, each with correct latency.
